// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encoding and the latency counter width.
package mdu_pkg;

   localparam int CNT_W = 16;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MFHI  = 4'd7;
   localparam logic [3:0] MDU_MFLO  = 4'd8;
   localparam logic [3:0] MDU_MADD  = 4'd9;
   localparam logic [3:0] MDU_MADDU = 4'd10;
   localparam logic [3:0] MDU_MSUB  = 4'd11;
   localparam logic [3:0] MDU_MSUBU = 4'd12;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed behaviourally at the start edge and held in a
// pending register; a down-counter only models the latency before commit.
// Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (codes 9-12);
// without it those codes behave as NONE.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] mdu_out
);

   mdu_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [63:0]       r_pending;
   logic [31:0]       r_hi;
   logic [31:0]       r_lo;

   // Full 64-bit products: sign- or zero-extend operands, keep low 64 bits
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign w_prod_u = {32'd0, A} * {32'd0, B};

   // Division on magnitudes, signs restored afterwards; this also yields
   // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
   logic        w_div_zero;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_sden;
   logic [31:0] w_uden;
   logic [31:0] w_sq_mag;
   logic [31:0] w_sr_mag;
   logic [31:0] w_sq;
   logic [31:0] w_sr;
   logic [31:0] w_uq;
   logic [31:0] w_ur;

   assign w_div_zero = (B == 32'd0);
   assign w_abs_a    = A[31] ? (32'd0 - A) : A;
   assign w_abs_b    = B[31] ? (32'd0 - B) : B;
   // Divisor forced to 1 on zero so the unused quotient stays defined
   assign w_sden     = w_div_zero ? 32'd1 : w_abs_b;
   assign w_uden     = w_div_zero ? 32'd1 : B;
   assign w_sq_mag   = w_abs_a / w_sden;
   assign w_sr_mag   = w_abs_a % w_sden;
   assign w_sq       = (A[31] ^ B[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
   assign w_sr       = A[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
   assign w_uq       = A / w_uden;
   assign w_ur       = A % w_uden;

`ifdef MDU_MADD_EN
   logic [63:0] w_hilo;
   assign w_hilo = {r_hi, r_lo};
`endif

   // FSM: accept ops in IDLE, count latency in BUSY, commit on the last cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_pending <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  case (mdu_op)
                     MDU_MULT, MDU_MULTU: begin
                        r_pending <= (mdu_op == MDU_MULT) ? w_prod_s : w_prod_u;
                        r_cnt     <= CNT_W'(MULT_CYCLES);
                        r_state   <= ST_BUSY;
                     end
                     MDU_DIV: begin
                        // Divide by zero keeps HI/LO by re-committing them
                        r_pending <= w_div_zero ? {r_hi, r_lo} : {w_sr, w_sq};
                        r_cnt     <= CNT_W'(DIV_CYCLES);
                        r_state   <= ST_BUSY;
                     end
                     MDU_DIVU: begin
                        r_pending <= w_div_zero ? {r_hi, r_lo} : {w_ur, w_uq};
                        r_cnt     <= CNT_W'(DIV_CYCLES);
                        r_state   <= ST_BUSY;
                     end
`ifdef MDU_MADD_EN
                     MDU_MADD: begin
                        r_pending <= w_hilo + w_prod_s;
                        r_cnt     <= CNT_W'(MULT_CYCLES);
                        r_state   <= ST_BUSY;
                     end
                     MDU_MADDU: begin
                        r_pending <= w_hilo + w_prod_u;
                        r_cnt     <= CNT_W'(MULT_CYCLES);
                        r_state   <= ST_BUSY;
                     end
                     MDU_MSUB: begin
                        r_pending <= w_hilo - w_prod_s;
                        r_cnt     <= CNT_W'(MULT_CYCLES);
                        r_state   <= ST_BUSY;
                     end
                     MDU_MSUBU: begin
                        r_pending <= w_hilo - w_prod_u;
                        r_cnt     <= CNT_W'(MULT_CYCLES);
                        r_state   <= ST_BUSY;
                     end
`endif
                     MDU_MTHI: r_hi <= A;
                     MDU_MTLO: r_lo <= A;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_hi    <= r_pending[63:32];
                  r_lo    <= r_pending[31:0];
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy    = (r_state == ST_BUSY);
   assign HI      = r_hi;
   assign LO      = r_lo;
   assign mdu_out = (mdu_op == MDU_MFHI) ? r_hi :
                    (mdu_op == MDU_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed testbench for mdu_unit with hand-computed expected values.
// Build with MDU_MADD_EN defined to exercise the multiply-accumulate ops.
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic [31:0] mdu_out;

   int n_checks = 0;
   int n_errors = 0;
   int n_cyc;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mdu_op  (mdu_op),
      .A       (a_in),
      .B       (b_in),
      .busy    (busy),
      .HI      (hi_out),
      .LO      (lo_out),
      .mdu_out (mdu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the start edge
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      $display("op=%0d A=0x%08h B=0x%08h", op, a, b);
      start  = 1'b1;
      mdu_op = op;
      a_in   = a;
      b_in   = b;
      @(negedge clk);
      start  = 1'b0;
      mdu_op = MDU_NONE;
   endtask

   // Counts falling edges on which busy reads 1; bounded
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_hilo(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
      check_val({tag, "_hi"}, hi_out, hi_e);
      check_val({tag, "_lo"}, lo_out, lo_e);
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      mdu_op = MDU_NONE;
      a_in   = '0;
      b_in   = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_hilo("rst", 32'd0, 32'd0);
      check_val("rst_out", mdu_out, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // MULT -2 * 3
      issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n_cyc);
      check_val("mult_cycles", n_cyc, 32'd5);
      check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // MULTU max * max
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(n_cyc);
      check_val("multu_cycles", n_cyc, 32'd5);
      check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

      // DIV -7 / 2
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n_cyc);
      check_val("div_cycles", n_cyc, 32'd10);
      check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // DIVU by zero: full latency, HI/LO unchanged
      issue(MDU_DIVU, 32'd7, 32'd0);
      wait_idle(n_cyc);
      check_val("divz_cycles", n_cyc, 32'd10);
      check_hilo("divz", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // DIV overflow case
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n_cyc);
      check_hilo("divovf", 32'd0, 32'h8000_0000);

      // DIVU 100 / 7
      issue(MDU_DIVU, 32'd100, 32'd7);
      wait_idle(n_cyc);
      check_hilo("divu", 32'd2, 32'd14);

      // MTHI then combinational reads
      issue(MDU_MTHI, 32'h1234_5678, 32'd0);
      check_val("mthi_busy", {31'd0, busy}, 32'd0);
      check_hilo("mthi", 32'h1234_5678, 32'd14);
      mdu_op = MDU_MFHI;
      #1;
      check_val("mfhi_out", mdu_out, 32'h1234_5678);
      mdu_op = MDU_MFLO;
      #1;
      check_val("mflo_out", mdu_out, 32'd14);
      mdu_op = MDU_NONE;
      @(negedge clk);

      // MTLO while busy is ignored; MFLO during busy returns old LO
      issue(MDU_MULT, 32'd2, 32'd3);
      issue(MDU_MTLO, 32'h0000_DEAD, 32'd0);
      check_val("mtlo_busy_lo", lo_out, 32'd14);
      mdu_op = MDU_MFLO;
      #1;
      check_val("mflo_busy_out", mdu_out, 32'd14);
      mdu_op = MDU_NONE;
      wait_idle(n_cyc);
      check_hilo("mult_small", 32'd0, 32'd6);

      // Divide by zero with MTLO attempted mid-flight: LO must survive
      issue(MDU_DIVU, 32'd5, 32'd0);
      issue(MDU_MTLO, 32'h0000_BEEF, 32'd0);
      wait_idle(n_cyc);
      check_hilo("divz_mtlo", 32'd0, 32'd6);

      // NONE and undefined codes: no effect
      issue(MDU_NONE, 32'h1111_1111, 32'd1);
      check_val("none_busy", {31'd0, busy}, 32'd0);
      issue(4'd15, 32'h2222_2222, 32'd1);
      check_val("undef_busy", {31'd0, busy}, 32'd0);
      check_hilo("undef", 32'd0, 32'd6);

      // Reset asserted in the second busy cycle
      issue(MDU_MULT, 32'd3, 32'd4);
      @(negedge clk);
      reset = 1'b0;
      #1;
      $display("reset asserted mid-operation");
      check_val("midrst_busy", {31'd0, busy}, 32'd0);
      check_hilo("midrst", 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      check_val("postrst_busy", {31'd0, busy}, 32'd0);
      check_hilo("postrst", 32'd0, 32'd0);

      // Multiply-accumulate
      issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
      issue(MDU_MTHI, 32'd0, 32'd0);
      issue(MDU_MADDU, 32'd1, 32'd1);
      wait_idle(n_cyc);
`ifdef MDU_MADD_EN
      check_val("maddu_cycles", n_cyc, 32'd5);
      check_hilo("maddu", 32'd1, 32'd0);
      issue(MDU_MSUB, 32'd2, 32'd3);
      wait_idle(n_cyc);
      check_val("msub_cycles", n_cyc, 32'd5);
      check_hilo("msub", 32'd0, 32'hFFFF_FFFA);
`else
      check_val("maddu_cycles", n_cyc, 32'd0);
      check_hilo("maddu", 32'd0, 32'hFFFF_FFFF);
      issue(MDU_MSUB, 32'd2, 32'd3);
      wait_idle(n_cyc);
      check_val("msub_cycles", n_cyc, 32'd0);
      check_hilo("msub", 32'd0, 32'hFFFF_FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Watchdog in case the sequence above stalls
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
